// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for a DIGITS-digit hex
// seven-segment display. The display value is double-buffered, so a new value
// only takes effect at a frame boundary. The driver also does leading-zero
// suppression and per-digit blanking.
// Optional feature: define SEG_SCANNER_DP_EN to add the dp_mask input and the
// dp output for decimal points.
module seven_segment_scanner #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     show,
   input  logic                  blank_lz,
`ifdef SEG_SCANNER_DP_EN
   input  logic [DIGITS-1:0]     dp_mask,
   output logic                  dp,
`endif
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tick
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   // The "off" patterns double as XOR masks that convert active-high data
   // to the polarity used on the board.
   localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   // Parameter sanity: reject illegal configurations at elaboration.
   generate
      if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
         $error("seven_segment_scanner: DIGITS must be in 1..8");
      end
      if (SCAN_DIV < 2) begin : g_bad_div
         $error("seven_segment_scanner: SCAN_DIV must be at least 2");
      end
   endgenerate

   // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b0111111;
         4'h1:    g = 7'b0000110;
         4'h2:    g = 7'b1011011;
         4'h3:    g = 7'b1001111;
         4'h4:    g = 7'b1100110;
         4'h5:    g = 7'b1101101;
         4'h6:    g = 7'b1111101;
         4'h7:    g = 7'b0000111;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1101111;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b1111100;
         4'hC:    g = 7'b0111001;
         4'hD:    g = 7'b1011110;
         4'hE:    g = 7'b1111001;
         4'hF:    g = 7'b1110001;
         default: g = 7'b0000000;
      endcase
      return g;
   endfunction

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic [DIGITS-1:0]   disp_show_q, disp_show_d;
   logic [4*DIGITS-1:0] pend_q, pend_d;
   logic [DIGITS-1:0]   pend_show_q, pend_show_d;
   logic                pend_valid_q, pend_valid_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_tick_q, frame_tick_d;

   logic                boundary_s;
   logic [3:0]          nib_s;
   logic                shown_s;
   logic                lz_s;
   logic                blank_s;
   logic [DIGITS-1:0]   an_hi_s;

   // Scan timing: dwell counter, digit index and frame-boundary detect.
   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      boundary_s = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d = {CNT_W{1'b0}};
         if (idx_q == IDX_LAST) begin
            idx_d      = {IDX_W{1'b0}};
            boundary_s = 1'b1;
         end else begin
            idx_d      = idx_q + 1'b1;
            boundary_s = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Double buffer: loads park in pend and move to disp at a frame boundary;
   // a load landing on the boundary goes straight to disp.
   always_comb begin
      disp_d       = disp_q;
      disp_show_d  = disp_show_q;
      pend_d       = pend_q;
      pend_show_d  = pend_show_q;
      pend_valid_d = pend_valid_q;
      if (boundary_s) begin
         if (load) begin
            disp_d      = value;
            disp_show_d = show;
         end else if (pend_valid_q) begin
            disp_d      = pend_q;
            disp_show_d = pend_show_q;
         end else begin
            disp_d      = disp_q;
         end
         pend_valid_d = 1'b0;
      end else if (load) begin
         pend_d       = value;
         pend_show_d  = show;
         pend_valid_d = 1'b1;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   // Select the active digit and decide whether it is blanked. Leading-zero
   // suppression looks at every nibble from the top digit down to idx.
   always_comb begin
      nib_s   = 4'h0;
      shown_s = 1'b0;
      lz_s    = 1'b1;
      an_hi_s = {DIGITS{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         an_hi_s[i] = (IDX_W'(i) == idx_q);
         nib_s      = nib_s | (disp_q[4*i +: 4] & {4{an_hi_s[i]}});
         shown_s    = shown_s | (disp_show_q[i] & an_hi_s[i]);
         lz_s       = lz_s & ~((IDX_W'(i) >= idx_q) & (disp_q[4*i +: 4] != 4'h0));
      end
      blank_s = ~shown_s | (blank_lz & (idx_q != {IDX_W{1'b0}}) & lz_s);
   end

   // Output stage: glyph and anode for the active digit, in board polarity.
   always_comb begin
      frame_tick_d = boundary_s;
      if (blank_s) begin
         seg_d = SEG_OFF;
         an_d  = AN_OFF;
      end else begin
         seg_d = hex_glyph(nib_s) ^ SEG_OFF;
         an_d  = an_hi_s ^ AN_OFF;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= {CNT_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         disp_q       <= {(4*DIGITS){1'b0}};
         disp_show_q  <= {DIGITS{1'b1}};
         pend_q       <= {(4*DIGITS){1'b0}};
         pend_show_q  <= {DIGITS{1'b0}};
         pend_valid_q <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         disp_show_q  <= disp_show_d;
         pend_q       <= pend_d;
         pend_show_q  <= pend_show_d;
         pend_valid_q <= pend_valid_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

`ifdef SEG_SCANNER_DP_EN
   localparam logic DP_OFF = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic              dp_q, dp_d;
   logic              dp_bit_s;

   // Decimal-point mask follows the same pend/disp path as show.
   always_comb begin
      disp_dp_d = disp_dp_q;
      pend_dp_d = pend_dp_q;
      if (boundary_s) begin
         if (load) begin
            disp_dp_d = dp_mask;
         end else if (pend_valid_q) begin
            disp_dp_d = pend_dp_q;
         end else begin
            disp_dp_d = disp_dp_q;
         end
      end else if (load) begin
         pend_dp_d = dp_mask;
      end else begin
         pend_dp_d = pend_dp_q;
      end
      dp_bit_s = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         dp_bit_s = dp_bit_s | (disp_dp_q[i] & an_hi_s[i]);
      end
      if (blank_s) begin
         dp_d = DP_OFF;
      end else begin
         dp_d = dp_bit_s ^ DP_OFF;
      end
   end

   // Decimal-point registers; points start dark out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_dp_q <= {DIGITS{1'b0}};
         pend_dp_q <= {DIGITS{1'b0}};
         dp_q      <= DP_OFF;
      end else begin
         disp_dp_q <= disp_dp_d;
         pend_dp_q <= pend_dp_d;
         dp_q      <= dp_d;
      end
   end

   assign dp = dp_q;
`else
   // No decimal-point path in this configuration.
`endif

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexed driver for a DIGITS-digit hex seven-segment display.
- Drives one shared segment bus and per-digit anode enables. Each digit is shown for SCAN_DIV clocks in turn.
- Display value is double-buffered: a new value is loaded via a `load` pulse and takes effect only at a frame boundary, so a scan never shows a half-updated value.
- Adds leading-zero suppression and per-digit masking. Used for CPU register/PC readout on the board.

Parameters:
- DIGITS, 4, number of digits driven; legal range 1..8.
- SCAN_DIV, 50000, clocks each digit stays active; legal minimum 2.
- ACTIVE_LOW, 1, 1 = common-anode board (segments and anodes active-low); 0 = active-high.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, where digit 0 is least significant
- load  input  1  single-cycle strobe that captures `value` (and `show`)
- show  input  DIGITS  per-digit enable, captured on `load`; 0 = digit blanked
- blank_lz  input  1  leading-zero suppression enable; live input, not captured
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- an  output  DIGITS  digit enables, one-hot when active, registered
- frame_tick  output  1  one-cycle pulse on each frame boundary

Behaviour:
- Reset (while `rst`=1, at every clock edge):
  - All internal registers are cleared: `cnt`=0, `idx`=0, `disp`=0, `disp_show`=all ones, `pend_valid`=0.
  - `seg`=all-off (7'h7F if ACTIVE_LOW, else 7'h00).
  - `an`=all inactive.
  - `frame_tick`=0.
  - Reset mid-frame aborts the scan, and any pending load is discarded.
- Scan counter and digit index:
  - `cnt` counts 0..SCAN_DIV-1.
  - When `cnt`==SCAN_DIV-1: `cnt`<=0 and `idx`<=`idx`+1, wrapping DIGITS-1 -> 0.
  - With DIGITS=1, `idx` stays 0.
- Frame boundary: the cycle in which `idx` wraps DIGITS-1 -> 0 (with DIGITS=1, every SCAN_DIV-th cycle).
  - `frame_tick`=1 for exactly that cycle, registered, aligned with `idx` becoming 0.
  - If `pend_valid`, then `disp`<=`pend` and `disp_show`<=`pend_show`, and `pend_valid`<=0.
- Load handling:
  - `load`=1 outside a boundary cycle: `pend`<=`value`, `pend_show`<=`show`, `pend_valid`<=1.
  - Repeated loads before a boundary overwrite the pending value; last one wins.
  - `load` coincident with a boundary bypasses the pending buffer: `disp`<=`value`, `disp_show`<=`show`, and `pend_valid`<=0.
- Output stage:
  - `seg` and `an` are registered from the current `idx` and `disp` (1-cycle latency).
  - Anode `idx` is active unless the digit is blanked.
  - A blanked digit drives its anode inactive and `seg` all-off.
- Digit blanked if either:
  - `disp_show[idx]`==0; or
  - `blank_lz`=1, `idx`>0, and all nibbles from DIGITS-1 down to `idx` are 0.
  - Digit 0 is never suppressed, so value 0 displays as "0".
- Glyphs (active-high form, {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - ACTIVE_LOW inverts both `seg` and `an`.
- Refresh period: DIGITS*SCAN_DIV clocks per frame.
- Invalid parameters (DIGITS outside 1..8, SCAN_DIV<2) are a static elaboration error.

Optional Feature:
- Macro SEG_SCANNER_DP_EN.
- Defined:
  - Adds input `dp_mask [DIGITS-1:0]`, captured and double-buffered exactly like `show`.
  - Adds registered output `dp`, which reflects the decimal-point bit of the active digit.
  - `dp` follows ACTIVE_LOW polarity and is forced off when the digit is blanked.
  - Reset value of `dp` is off.
- Undefined: no `dp` or `dp_mask` ports, and no related logic.

Test Plan:
- Reset then release, DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1 -> `seg`=7'h7F and `an`=4'hF during reset; then `an` sequence E,D,B,7 each held 4 cycles; `frame_tick` pulses every 16 clocks.
- `load` with `value`=16'h12AF, `show`=4'hF, mid-frame -> no change until the next `frame_tick`; then digits 0..3 show `seg` 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1).
- `blank_lz`=1, `value`=16'h0040 loaded -> digits 3 and 2 blanked (`an` bit high, `seg`=7F); digit 1 shows "4"; digit 0 shows "0". `value`=0 -> only digit 0 lit, showing 1000000.
- Two loads (16'h1111 then 16'h2222) inside one frame -> only 2222 displayed after the boundary. A load on the exact boundary cycle -> applied in that same frame.
- `show`=4'b0101 with `value`=16'h8888 -> digits 1 and 3 never have active anodes; digits 0 and 2 show 0000000.
- `rst` asserted mid-frame with a load pending -> outputs off the next cycle; after release `disp`=0, the pending value is discarded, and the scan restarts at digit 0.
